mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle control FSM for the MIPS-lite datapath. It sequences instruction fetch, decode, execute, memory access and register-file writeback over several cycles, so one ALU, one memory port and the GRF write port are shared across phases. It produces every datapath enable and mux select from its state and the IR opcode/func fields. It sits beside the datapath top, and the datapath holds the PC, IR, A/B, ALUOut and MDR registers.

Parameters:
FETCH_WAIT, 0, extra wait cycles in FETCH before the IR/PC update (slow instruction memory); range 0..15
MEM_WAIT, 0, extra wait cycles in MEM before the data-memory write or MDR capture; range 0..15

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
op  input  6  IR[31:26]; valid from DECODE onward
func  input  6  IR[5:0]; valid from DECODE onward
zero  input  1  ALU equal flag; sampled in EXEC for beq
pc_we  output  1  PC register load
ir_we  output  1  IR load
reg_we  output  1  GRF write enable
reg_dst  output  2  write address select: 0 rt, 1 rd, 2 $31
wd_sel  output  2  write data select: 0 ALUOut, 1 MDR, 2 PC+4
alu_src_b  output  1  0 B register, 1 extended immediate
alu_op  output  3  0 add, 1 sub, 2 or, 3 lui (imm<<16)
ext_op  output  2  0 zero-extend, 1 sign-extend, 2 upper
dm_we  output  1  data-memory write
npc_sel  output  2  0 PC+4, 1 branch target, 2 jump target, 3 rs
state  output  3  current state (debug/bench)
instr_done  output  1  1-cycle pulse in the final cycle of each instruction
illegal  output  1  1-cycle pulse in DECODE for an unsupported op/func

Behaviour:
- Reset is synchronous. On a reset edge: state=FETCH, wait counter=0. pc_we, ir_we, reg_we and dm_we are combinationally gated low while reset=1, so a reset arriving mid-instruction performs no writes at that edge.
- States: FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4). Outputs are Moore, decoded from the state plus the latched op/func.
- FETCH: a 4-bit counter runs 0..FETCH_WAIT. pc_we=1, ir_we=1 and npc_sel=0 only when cnt==FETCH_WAIT, then go to DECODE and clear the counter.
- DECODE transitions:
  - op=0 and func==0 (nop): instr_done=1, go to FETCH.
  - j: npc_sel=2, pc_we=1, done, go to FETCH.
  - jal: as j, plus reg_we=1, reg_dst=2, wd_sel=2; go to FETCH.
  - op=0 and func=jr: npc_sel=3, pc_we=1, done, go to FETCH.
  - unsupported op/func: illegal=1, instr_done=1, no writes, go to FETCH.
  - all other supported instructions: go to EXEC.
- EXEC:
  - addu: alu_op=0, src_b=0; go to WB.
  - subu: alu_op=1, src_b=0; go to WB.
  - ori: alu_op=2, ext=0, src_b=1; go to WB.
  - lui: alu_op=3, ext=2, src_b=1; go to WB.
  - lw/sw: alu_op=0, ext=1, src_b=1; go to MEM.
  - beq: alu_op=1, src_b=0. If zero=1, npc_sel=1 and pc_we=1. instr_done=1, go to FETCH.
- MEM: the counter runs 0..MEM_WAIT.
  - sw: dm_we=1 only when cnt==MEM_WAIT, instr_done, go to FETCH.
  - lw: go to WB after cnt==MEM_WAIT.
- WB: reg_we=1 for one cycle, instr_done=1, go to FETCH.
  - R-type: reg_dst=1, wd_sel=0.
  - ori/lui: reg_dst=0, wd_sel=0.
  - lw: reg_dst=0, wd_sel=1.
- Cycle counts with zero waits: nop/j/jal/jr 2, beq 3, R/ori/lui/sw 4, lw 5. FETCH adds FETCH_WAIT cycles; lw/sw add MEM_WAIT cycles.
- Writes to $0 are suppressed by the GRF, not by this block.
- Default values outside the cases above: all enables 0, all selects 0.
- The state register never holds a value above 4. Illegal encodings recover to FETCH on the next edge.

Decomposition:
- Shared package (define header) holds:
  - opcode/func constants: addu, subu, ori, lui, lw, sw, beq, j, jal, jr;
  - state encodings;
  - alu_op, ext_op, npc_sel, reg_dst and wd_sel codes.
- One sub-module, mc_decode: combinational op/func to instruction class (R_ALU, I_ALU, LOAD, STORE, BRANCH, JUMP, JAL, JR, NOP, ILLEGAL). The FSM switches on this class only.

Test Plan:
- addu (op 0, func 0x21), waits 0 -> states 0,1,2,4; reg_we=1 with reg_dst=1, wd_sel=0 in cycle 4 only; instr_done in cycle 4.
- lw (op 0x23), MEM_WAIT=2 -> MEM lasts 3 cycles with dm_we=0; WB follows with reg_we=1, wd_sel=1; total 7 cycles.
- beq (op 0x04), first with zero=1, then with zero=0:
  - zero=1: pc_we=1 and npc_sel=1 in EXEC.
  - zero=0: pc_we=0 in EXEC.
  - both: done after 3 cycles, no reg_we or dm_we.
- jal (op 0x03) -> DECODE shows pc_we=1, npc_sel=2, reg_we=1, reg_dst=2, wd_sel=2; 2 cycles total.
- sw with reset asserted in the MEM cycle where cnt==MEM_WAIT -> dm_we stays 0; next state FETCH; counter 0.
- op 0x3F -> illegal=1 and instr_done=1 in DECODE, no write enables, FETCH next; FETCH_WAIT=3 gives ir_we exactly in the 4th FETCH cycle.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-lite controller: opcodes, states, instruction classes and datapath select codes.
// Pure definitions: no latency or flow-control behaviour of its own.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_R_ALU   = 4'd0,
        C_I_ALU   = 4'd1,
        C_LOAD    = 4'd2,
        C_STORE   = 4'd3,
        C_BRANCH  = 4'd4,
        C_JUMP    = 4'd5,
        C_JAL     = 4'd6,
        C_JR      = 4'd7,
        C_NOP     = 4'd8,
        C_ILLEGAL = 4'd9
    } iclass_t;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_LUI  = 3'd3;

    localparam logic [1:0] EXT_ZERO  = 2'd0;
    localparam logic [1:0] EXT_SIGN  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JUMP = 2'd2;
    localparam logic [1:0] NPC_RS   = 2'd3;

    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_RA   = 2'd2;

    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_MDR   = 2'd1;
    localparam logic [1:0] WD_PC4   = 2'd2;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] ext_op;
        logic       dm_we;
        logic [1:0] npc_sel;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/func to instruction class, plus the ALU/extender setting that class uses in EXEC.
// Zero latency, no flow control.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output logic [3:0] iclass_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] ext_op_o
);

    iclass_t cls;

    always_comb begin
        cls      = C_ILLEGAL;
        alu_op_o = ALU_ADD;
        ext_op_o = EXT_ZERO;
        case (op_i)
            OP_RTYPE: begin
                case (func_i)
                    FN_NOP:  cls = C_NOP;
                    FN_JR:   cls = C_JR;
                    FN_ADDU: cls = C_R_ALU;
                    FN_SUBU: begin
                        cls      = C_R_ALU;
                        alu_op_o = ALU_SUB;
                    end
                    default: cls = C_ILLEGAL;
                endcase
            end
            OP_ORI: begin
                cls      = C_I_ALU;
                alu_op_o = ALU_OR;
            end
            OP_LUI: begin
                cls      = C_I_ALU;
                alu_op_o = ALU_LUI;
                ext_op_o = EXT_UPPER;
            end
            OP_LW: begin
                cls      = C_LOAD;
                ext_op_o = EXT_SIGN;
            end
            OP_SW: begin
                cls      = C_STORE;
                ext_op_o = EXT_SIGN;
            end
            OP_BEQ: begin
                cls      = C_BRANCH;
                alu_op_o = ALU_SUB;
            end
            OP_J:    cls = C_JUMP;
            OP_JAL:  cls = C_JAL;
            default: cls = C_ILLEGAL;
        endcase
    end

    assign iclass_o = cls;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-lite control FSM: FETCH/DECODE/EXEC/MEM/WB, 2..5 cycles per instruction plus FETCH_WAIT/MEM_WAIT stalls.
// No backpressure; stalls are fixed by parameters, and write enables are forced low while reset is high.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned FETCH_WAIT = 0,
    parameter int unsigned MEM_WAIT   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] ext_op,
    output logic       dm_we,
    output logic [1:0] npc_sel,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [3:0] FETCH_LAST = 4'(FETCH_WAIT);
    localparam logic [3:0] MEM_LAST   = 4'(MEM_WAIT);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [3:0] iclass_raw;
    logic [2:0] dec_alu_op;
    logic [1:0] dec_ext_op;
    iclass_t    iclass;
    ctrl_t      ctrl;

    mc_decode u_decode (
        .op_i     (op),
        .func_i   (func),
        .iclass_o (iclass_raw),
        .alu_op_o (dec_alu_op),
        .ext_op_o (dec_ext_op)
    );

    assign iclass = iclass_t'(iclass_raw);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (cnt_q == FETCH_LAST) begin
                        state_q <= S_DECODE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_DECODE: begin
                    case (iclass)
                        C_NOP, C_JUMP, C_JAL, C_JR, C_ILLEGAL: state_q <= S_FETCH;
                        default:                               state_q <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (iclass)
                        C_R_ALU, C_I_ALU: state_q <= S_WB;
                        C_LOAD, C_STORE:  state_q <= S_MEM;
                        default:          state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (cnt_q == MEM_LAST) begin
                        state_q <= (iclass == C_LOAD) ? S_WB : S_FETCH;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                default: begin
                    state_q <= S_FETCH;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Moore decode: the IR is stable from DECODE onward, so class-dependent outputs never glitch mid-state.
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                if (cnt_q == FETCH_LAST) begin
                    ctrl.pc_we   = 1'b1;
                    ctrl.ir_we   = 1'b1;
                    ctrl.npc_sel = NPC_PC4;
                end
            end
            S_DECODE: begin
                case (iclass)
                    C_NOP: ctrl.instr_done = 1'b1;
                    C_JUMP: begin
                        ctrl.pc_we      = 1'b1;
                        ctrl.npc_sel    = NPC_JUMP;
                        ctrl.instr_done = 1'b1;
                    end
                    C_JAL: begin
                        ctrl.pc_we      = 1'b1;
                        ctrl.npc_sel    = NPC_JUMP;
                        ctrl.reg_we     = 1'b1;
                        ctrl.reg_dst    = DST_RA;
                        ctrl.wd_sel     = WD_PC4;
                        ctrl.instr_done = 1'b1;
                    end
                    C_JR: begin
                        ctrl.pc_we      = 1'b1;
                        ctrl.npc_sel    = NPC_RS;
                        ctrl.instr_done = 1'b1;
                    end
                    C_ILLEGAL: begin
                        ctrl.illegal    = 1'b1;
                        ctrl.instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                ctrl.alu_op    = dec_alu_op;
                ctrl.ext_op    = dec_ext_op;
                ctrl.alu_src_b = (iclass == C_I_ALU) || (iclass == C_LOAD) || (iclass == C_STORE);
                if (iclass == C_BRANCH) begin
                    ctrl.pc_we      = zero;
                    ctrl.npc_sel    = zero ? NPC_BR : NPC_PC4;
                    ctrl.instr_done = 1'b1;
                end
            end
            S_MEM: begin
                if ((iclass == C_STORE) && (cnt_q == MEM_LAST)) begin
                    ctrl.dm_we      = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
            end
            S_WB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.reg_dst    = (iclass == C_R_ALU) ? DST_RD : DST_RT;
                ctrl.wd_sel     = (iclass == C_LOAD) ? WD_MDR : WD_ALU;
                ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_we      = ctrl.pc_we  & ~reset;
    assign ir_we      = ctrl.ir_we  & ~reset;
    assign reg_we     = ctrl.reg_we & ~reset;
    assign dm_we      = ctrl.dm_we  & ~reset;
    assign reg_dst    = ctrl.reg_dst;
    assign wd_sel     = ctrl.wd_sel;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign ext_op     = ctrl.ext_op;
    assign npc_sel    = ctrl.npc_sel;
    assign instr_done = ctrl.instr_done;
    assign illegal    = ctrl.illegal;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: three configurations run side by side against a per-cycle instruction model.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] ext_op;
        logic       dm_we;
        logic [1:0] npc_sel;
        logic       instr_done;
        logic       illegal;
    } obs_t;

    typedef enum int {K_NOP, K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_BAD} kind_e;

    localparam logic [11:0] POOL [13] = '{
        {6'h00, 6'h00}, {6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h08}, {6'h00, 6'h22},
        {6'h0D, 6'h00}, {6'h0F, 6'h00}, {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h04, 6'h00},
        {6'h02, 6'h00}, {6'h03, 6'h00}, {6'h3F, 6'h00}
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      rst;
    logic [2:0][5:0] op_v;
    logic [2:0][5:0] func_v;
    logic [2:0]      zero_v;
    logic [2:0]      pc_we_v, ir_we_v, reg_we_v, alu_src_b_v, dm_we_v, done_v, illegal_v;
    logic [2:0][1:0] reg_dst_v, wd_sel_v, ext_op_v, npc_sel_v;
    logic [2:0][2:0] alu_op_v, state_v;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mc_ctrl #(
            .FETCH_WAIT (g == 2 ? 3 : 0),
            .MEM_WAIT   (g == 1 ? 2 : (g == 2 ? 1 : 0))
        ) u_dut (
            .clk        (clk),
            .reset      (rst[g]),
            .op         (op_v[g]),
            .func       (func_v[g]),
            .zero       (zero_v[g]),
            .pc_we      (pc_we_v[g]),
            .ir_we      (ir_we_v[g]),
            .reg_we     (reg_we_v[g]),
            .reg_dst    (reg_dst_v[g]),
            .wd_sel     (wd_sel_v[g]),
            .alu_src_b  (alu_src_b_v[g]),
            .alu_op     (alu_op_v[g]),
            .ext_op     (ext_op_v[g]),
            .dm_we      (dm_we_v[g]),
            .npc_sel    (npc_sel_v[g]),
            .state      (state_v[g]),
            .instr_done (done_v[g]),
            .illegal    (illegal_v[g])
        );
    end

    obs_t exp_q [3][$];
    int   checks = 0;
    int   failures = 0;
    int   cyc [3] = '{0, 0, 0};

    function automatic int fw_of(input int d);
        return (d == 2) ? 3 : 0;
    endfunction

    function automatic int mw_of(input int d);
        return (d == 1) ? 2 : ((d == 2) ? 1 : 0);
    endfunction

    function automatic obs_t observe(input int d);
        obs_t o;
        o.state      = state_v[d];
        o.pc_we      = pc_we_v[d];
        o.ir_we      = ir_we_v[d];
        o.reg_we     = reg_we_v[d];
        o.reg_dst    = reg_dst_v[d];
        o.wd_sel     = wd_sel_v[d];
        o.alu_src_b  = alu_src_b_v[d];
        o.alu_op     = alu_op_v[d];
        o.ext_op     = ext_op_v[d];
        o.dm_we      = dm_we_v[d];
        o.npc_sel    = npc_sel_v[d];
        o.instr_done = done_v[d];
        o.illegal    = illegal_v[d];
        return o;
    endfunction

    function automatic obs_t blank(input int st);
        obs_t o = '0;
        o.state = 3'(st);
        return o;
    endfunction

    function automatic kind_e kind_of(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) begin
            case (f)
                6'h00:   return K_NOP;
                6'h21:   return K_ADDU;
                6'h23:   return K_SUBU;
                6'h08:   return K_JR;
                default: return K_BAD;
            endcase
        end
        case (o)
            6'h0D:   return K_ORI;
            6'h0F:   return K_LUI;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            default: return K_BAD;
        endcase
    endfunction

    // Expected per-cycle output trace of one instruction; returns its length in cycles.
    task automatic model(input int d, input logic [5:0] o, input logic [5:0] f, input logic z,
                         input bit rst_mem, output int n);
        kind_e k = kind_of(o, f);
        obs_t  r;
        n = 0;
        for (int i = 0; i < fw_of(d); i++) begin
            exp_q[d].push_back(blank(0));
            n++;
        end
        r = blank(0);
        r.pc_we = 1'b1;
        r.ir_we = 1'b1;
        exp_q[d].push_back(r);
        n++;

        r = blank(1);
        case (k)
            K_NOP: r.instr_done = 1'b1;
            K_J:   begin r.pc_we = 1'b1; r.npc_sel = 2'd2; r.instr_done = 1'b1; end
            K_JAL: begin
                r.pc_we = 1'b1; r.npc_sel = 2'd2; r.reg_we = 1'b1;
                r.reg_dst = 2'd2; r.wd_sel = 2'd2; r.instr_done = 1'b1;
            end
            K_JR:  begin r.pc_we = 1'b1; r.npc_sel = 2'd3; r.instr_done = 1'b1; end
            K_BAD: begin r.illegal = 1'b1; r.instr_done = 1'b1; end
            default: ;
        endcase
        exp_q[d].push_back(r);
        n++;
        if (k inside {K_NOP, K_J, K_JAL, K_JR, K_BAD}) return;

        r = blank(2);
        case (k)
            K_ADDU: r.alu_op = 3'd0;
            K_SUBU: r.alu_op = 3'd1;
            K_ORI:  begin r.alu_op = 3'd2; r.ext_op = 2'd0; r.alu_src_b = 1'b1; end
            K_LUI:  begin r.alu_op = 3'd3; r.ext_op = 2'd2; r.alu_src_b = 1'b1; end
            K_LW, K_SW: begin r.alu_op = 3'd0; r.ext_op = 2'd1; r.alu_src_b = 1'b1; end
            K_BEQ:  begin
                r.alu_op = 3'd1;
                r.pc_we = z;
                r.npc_sel = z ? 2'd1 : 2'd0;
                r.instr_done = 1'b1;
            end
            default: ;
        endcase
        exp_q[d].push_back(r);
        n++;
        if (k == K_BEQ) return;

        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= mw_of(d); i++) begin
                r = blank(3);
                if (k == K_SW && i == mw_of(d)) begin
                    r.dm_we = !rst_mem;
                    r.instr_done = 1'b1;
                end
                exp_q[d].push_back(r);
                n++;
            end
            if (k == K_SW) return;
        end

        r = blank(4);
        r.reg_we = 1'b1;
        r.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
        r.wd_sel = (k == K_LW) ? 2'd1 : 2'd0;
        r.instr_done = 1'b1;
        exp_q[d].push_back(r);
        n++;
    endtask

    task automatic run_instr(input int d, input logic [5:0] o, input logic [5:0] f, input logic z,
                             input bit rst_mem);
        int n;
        op_v[d]   = o;
        func_v[d] = f;
        zero_v[d] = z;
        model(d, o, f, z, rst_mem, n);
        if (rst_mem) begin
            repeat (n - 1) @(posedge clk);
            #1;
            rst[d] = 1'b1;
            @(posedge clk);
            #1;
            rst[d] = 1'b0;
        end else begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int d);
        int idx;
        case (d)
            0: begin
                run_instr(0, 6'h00, 6'h21, 1'b0, 1'b0);
                run_instr(0, 6'h04, 6'h00, 1'b1, 1'b0);
                run_instr(0, 6'h04, 6'h00, 1'b0, 1'b0);
                run_instr(0, 6'h03, 6'h00, 1'b0, 1'b0);
                run_instr(0, 6'h2B, 6'h00, 1'b0, 1'b1);
                run_instr(0, 6'h00, 6'h08, 1'b0, 1'b0);
            end
            1: begin
                run_instr(1, 6'h23, 6'h00, 1'b0, 1'b0);
                run_instr(1, 6'h2B, 6'h05, 1'b0, 1'b1);
                run_instr(1, 6'h2B, 6'h00, 1'b0, 1'b0);
                run_instr(1, 6'h0F, 6'h00, 1'b0, 1'b0);
            end
            default: begin
                run_instr(2, 6'h3F, 6'h00, 1'b0, 1'b0);
                run_instr(2, 6'h00, 6'h23, 1'b0, 1'b0);
                run_instr(2, 6'h2B, 6'h00, 1'b0, 1'b1);
                run_instr(2, 6'h23, 6'h00, 1'b0, 1'b0);
            end
        endcase
        for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(0, 12);
            run_instr(d, POOL[idx][11:6],
                      (POOL[idx][11:6] == 6'h00) ? POOL[idx][5:0] : 6'($urandom),
                      1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        for (int d = 0; d < 3; d++) begin
            if (exp_q[d].size() > 0) begin
                e = exp_q[d].pop_front();
                a = observe(d);
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL dut%0d cycle %0d: actual=%h (state %0d) required=%h (state %0d)",
                             d, cyc[d], a, a.state, e, e.state);
                end
                cyc[d]++;
            end
        end
    end

    initial begin
        rst    = 3'b111;
        op_v   = '0;
        func_v = '0;
        zero_v = '0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            exp_q[d].push_back(blank(0));
            exp_q[d].push_back(blank(0));
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 3'b000;
        fork
            drive(0);
            drive(1);
            drive(2);
        join
        @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (exp_q[d].size() != 0) begin
                failures++;
                $display("FAIL dut%0d drain: leftover=%0d required=0", d, exp_q[d].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
